// File: rtl/sha256_msg_sequencer.sv
// Multi-block message sequencer for the single-block SHA-256 core: issues padded
// blocks, chains them through the core, returns the final digest and watchdogs the core.
module sha256_msg_sequencer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [511:0]     s_block,
    input  logic             s_last,
    output logic             core_start_block,
    output logic             core_block_valid,
    output logic [511:0]     core_block_in,
    input  logic             core_busy,
    input  logic             core_comp_done,
    input  logic [255:0]     core_hash_out,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [255:0]     m_digest,
    output logic [CNT_W-1:0] m_blocks,
    output logic             err_timeout,
    output logic             busy
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Block counter never wraps; it sticks at all-ones on very long messages.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_W'(1'b1);
        end
    endfunction

    state_t             state_r, state_s;
    logic               first_flag_r, first_flag_s;
    logic               last_q_r, last_q_s;
    logic [CNT_W-1:0]   blk_cnt_r, blk_cnt_s;
    logic [TO_W-1:0]    to_cnt_r, to_cnt_s;
    logic               s_ready_r, s_ready_s;
    logic               start_r, start_s;
    logic               bv_r, bv_s;
    logic [511:0]       block_in_r, block_in_s;
    logic               m_valid_r, m_valid_s;
    logic [255:0]       m_digest_r, m_digest_s;
    logic [CNT_W-1:0]   m_blocks_r, m_blocks_s;
    logic               err_r, err_s;
    logic               busy_r, busy_s;

    assign s_ready          = s_ready_r;
    assign core_start_block = start_r;
    assign core_block_valid = bv_r;
    assign core_block_in    = block_in_r;
    assign m_valid          = m_valid_r;
    assign m_digest         = m_digest_r;
    assign m_blocks         = m_blocks_r;
    assign err_timeout      = err_r;
    assign busy             = busy_r;

    // Next-state and next-output computation for the sequencer FSM.
    always_comb begin
        state_s      = state_r;
        first_flag_s = first_flag_r;
        last_q_s     = last_q_r;
        blk_cnt_s    = blk_cnt_r;
        to_cnt_s     = to_cnt_r;
        block_in_s   = block_in_r;
        start_s      = 1'b0;
        bv_s         = 1'b0;
        m_valid_s    = m_valid_r;
        m_digest_s   = m_digest_r;
        m_blocks_s   = m_blocks_r;
        err_s        = err_r;
        s_ready_s    = 1'b0;
        busy_s       = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (s_valid && s_ready_r) begin
                    block_in_s = s_block;
                    last_q_s   = s_last;
                    if (first_flag_r) begin
                        blk_cnt_s = {CNT_W{1'b0}};
                        err_s     = 1'b0;
                    end else begin
                        blk_cnt_s = blk_cnt_r;
                    end
                    bv_s     = 1'b1;
                    start_s  = first_flag_r;
                    to_cnt_s = {TO_W{1'b0}};
                    state_s  = ST_WAIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // A completion arriving on the timeout cycle still counts as success.
                if (core_comp_done) begin
                    blk_cnt_s = sat_inc(blk_cnt_r);
                    if (last_q_r) begin
                        m_digest_s = core_hash_out;
                        m_blocks_s = sat_inc(blk_cnt_r);
                        m_valid_s  = 1'b1;
                        state_s    = ST_OUT;
                    end else begin
                        first_flag_s = 1'b0;
                        state_s      = ST_IDLE;
                    end
                end else if (to_cnt_r == TO_LAST) begin
                    err_s        = 1'b1;
                    first_flag_s = 1'b1;
                    state_s      = ST_IDLE;
                end else begin
                    to_cnt_s = to_cnt_r + TO_W'(1'b1);
                end
            end
            ST_OUT: begin
                if (m_ready) begin
                    m_valid_s    = 1'b0;
                    first_flag_s = 1'b1;
                    state_s      = ST_IDLE;
                end else begin
                    state_s = ST_OUT;
                end
            end
            default: begin
                state_s      = ST_IDLE;
                first_flag_s = 1'b1;
            end
        endcase

        // Intake is only offered from IDLE and while the core reports idle.
        s_ready_s = (state_s == ST_IDLE) && !core_busy;
        busy_s    = (state_s != ST_IDLE) || !first_flag_s;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            first_flag_r <= 1'b1;
            last_q_r     <= 1'b0;
            blk_cnt_r    <= {CNT_W{1'b0}};
            to_cnt_r     <= {TO_W{1'b0}};
            s_ready_r    <= 1'b0;
            start_r      <= 1'b0;
            bv_r         <= 1'b0;
            block_in_r   <= 512'd0;
            m_valid_r    <= 1'b0;
            m_digest_r   <= 256'd0;
            m_blocks_r   <= {CNT_W{1'b0}};
            err_r        <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            first_flag_r <= first_flag_s;
            last_q_r     <= last_q_s;
            blk_cnt_r    <= blk_cnt_s;
            to_cnt_r     <= to_cnt_s;
            s_ready_r    <= s_ready_s;
            start_r      <= start_s;
            bv_r         <= bv_s;
            block_in_r   <= block_in_s;
            m_valid_r    <= m_valid_s;
            m_digest_r   <= m_digest_s;
            m_blocks_r   <= m_blocks_s;
            err_r        <= err_s;
            busy_r       <= busy_s;
        end
    end

endmodule
